// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one unsigned multiplier among NUM_REQ requesters.
// The accepted operand pair is multiplied in the accept cycle and the truncated
// product lands in a single-entry output register tagged with the requester index.
module mul_share_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned A_WIDTH   = 9,
    parameter int unsigned B_WIDTH   = 5,
    parameter int unsigned P_WIDTH   = 13,
    parameter int unsigned ID_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic [CNT_WIDTH-1:0]         op_count
);

    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic [ID_WIDTH-1:0] ptr_next;
    logic                gnt_found;
    logic                slot_free;
    logic                accept;
    logic [A_WIDTH-1:0]  a_sel;
    logic [B_WIDTH-1:0]  b_sel;
    logic [P_WIDTH-1:0]  prod;

    // The output register can take a new product if empty or being drained now.
    assign slot_free = !rsp_valid || rsp_ready;

    // Search requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant is suppressed during reset so nothing is handed out while state is cleared.
    always_comb begin
        accept    = ap_rst_n && slot_free && gnt_found;
        req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
        ptr_next  = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
    end

    // Operand mux and multiply; only the low P_WIDTH product bits are ever needed,
    // so the multiply is done at that width (low bits depend only on low operand bits).
    always_comb begin
        a_sel = req_a[32'(gnt_idx) * A_WIDTH +: A_WIDTH];
        b_sel = req_b[32'(gnt_idx) * B_WIDTH +: B_WIDTH];
        prod  = P_WIDTH'(a_sel) * P_WIDTH'(b_sel);
    end

    // Output register, pointer and saturating operation counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            op_count  <= '0;
        end else if (accept) begin
            ptr_q     <= ptr_next;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_p     <= prod;
            if (op_count != '1) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end else if (rsp_ready) begin
            // Drained with nothing new: id and product keep their last values.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed sequences, a vector table
// and random traffic compared against a distance-based round-robin model.
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int BW = 5;
    localparam int PW = 13;
    localparam int IW = 2;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    v;
    logic [N-1:0]    ready;
    logic [N*AW-1:0] bus_a;
    logic [N*BW-1:0] bus_b;
    logic            rr;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [PW-1:0]   rsp_p;
    logic [CW-1:0]   op_count;

    logic [AW-1:0]   ta  [N];
    logic [BW-1:0]   tbv [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign bus_a[gi*AW +: AW] = ta[gi];
        assign bus_b[gi*BW +: BW] = tbv[gi];
    end

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NUM_REQ  (N),
        .A_WIDTH  (AW),
        .B_WIDTH  (BW),
        .P_WIDTH  (PW),
        .ID_WIDTH (IW),
        .CNT_WIDTH(CW)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .req_valid(v),
        .req_ready(ready),
        .req_a    (bus_a),
        .req_b    (bus_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rr),
        .rsp_id   (rsp_id),
        .rsp_p    (rsp_p),
        .op_count (op_count)
    );

    int          total = 0;
    int          bad   = 0;
    int          m_valid;
    int          m_id;
    int          m_p;
    longint      m_cnt;
    int          m_ptr;
    logic [N-1:0] last_ready;

    typedef struct {
        int            req;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [PW-1:0] p;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_id    = 0;
        m_p     = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // Winner is the valid requester closest to the pointer going upward, mod N.
    function automatic int model_grant();
        int best;
        int bestd;
        int d;
        if (!rst_n) return -1;
        if (m_valid != 0 && !rr) return -1;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // Entered at posedge+1 with inputs set; checks ready, clocks once, checks outputs.
    task automatic cycle(input string tag);
        int           g;
        int           ga;
        int           gb;
        logic         rrs;
        logic [N-1:0] exp_ready;
        #1;
        g         = model_grant();
        exp_ready = '0;
        ga        = 0;
        gb        = 0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ga = int'(ta[g]);
            gb = int'(tbv[g]);
        end
        rrs        = rr;
        last_ready = ready;
        chk({tag, "_ready"}, ready, exp_ready);
        @(posedge clk);
        if (g >= 0) begin
            m_p     = (ga * gb) % (1 << PW);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end else if (rrs) begin
            m_valid = 0;
        end
        #1;
        chk({tag, "_valid"}, rsp_valid, m_valid);
        chk({tag, "_id"}, rsp_id, m_id);
        chk({tag, "_p"}, rsp_p, m_p);
        chk({tag, "_cnt"}, op_count, m_cnt);
    endtask

    initial begin
        tbl[0] = '{0, 9'd511, 5'd31, 13'd7649};
        tbl[1] = '{1, 9'd0,   5'd31, 13'd0};
        tbl[2] = '{2, 9'd511, 5'd1,  13'd511};
        tbl[3] = '{3, 9'd256, 5'd16, 13'd4096};
        tbl[4] = '{0, 9'd300, 5'd20, 13'd6000};
        tbl[5] = '{1, 9'd400, 5'd25, 13'd1808};
        tbl[6] = '{2, 9'd511, 5'd16, 13'd8176};
        tbl[7] = '{3, 9'd100, 5'd7,  13'd700};

        for (int i = 0; i < N; i++) begin
            ta[i]  = '0;
            tbv[i] = '0;
        end
        rst_n = 1'b0;
        v     = '1;
        rr    = 1'b0;
        #3;
        chk("rst_ready", ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_p", rsp_p, 0);
        chk("rst_cnt", op_count, 0);
        model_reset();
        @(negedge clk);
        v     = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transaction after reset
        v      = 4'b0100;
        ta[2]  = 9'd100;
        tbv[2] = 5'd7;
        rr     = 1'b1;
        cycle("t1");
        chk("t1_ready_exact", last_ready, 4'b0100);
        chk("t1_valid_exact", rsp_valid, 1);
        chk("t1_id_exact", rsp_id, 2);
        chk("t1_p_exact", rsp_p, 700);
        chk("t1_cnt_exact", op_count, 1);

        // Pointer after a grant to 3 favours 0 over 3
        v      = 4'b1000;
        ta[3]  = 9'd5;
        tbv[3] = 5'd5;
        cycle("t5a");
        chk("t5a_ready_exact", last_ready, 4'b1000);
        v      = 4'b1001;
        ta[0]  = 9'd2;
        tbv[0] = 5'd2;
        cycle("t5b");
        chk("t5b_ready_exact", last_ready, 4'b0001);
        chk("t5b_id_exact", rsp_id, 0);
        v = 4'b1000;
        cycle("t5c");
        chk("t5c_id_exact", rsp_id, 3);

        // All requesters valid: strict rotation, no bubbles
        v = 4'b1111;
        for (int i = 0; i < N; i++) begin
            ta[i]  = AW'(i + 1);
            tbv[i] = 5'd3;
        end
        for (int k = 0; k < 5; k++) begin
            cycle("t3");
            chk("t3_p_exact", rsp_p, 3 * ((k % 4) + 1));
            chk("t3_valid_exact", rsp_valid, 1);
        end

        // Backpressure: hold product, then drain and accept in the same cycle
        rr     = 1'b0;
        v      = 4'b0010;
        ta[1]  = 9'd20;
        tbv[1] = 5'd5;
        for (int k = 0; k < 3; k++) begin
            cycle("t4_hold");
            chk("t4_hold_ready", last_ready, 0);
            chk("t4_hold_p", rsp_p, 3);
            chk("t4_hold_id", rsp_id, 0);
        end
        rr = 1'b1;
        cycle("t4_go");
        chk("t4_go_ready", last_ready, 4'b0010);
        chk("t4_go_valid", rsp_valid, 1);
        chk("t4_go_p", rsp_p, 100);
        chk("t4_go_id", rsp_id, 1);
        v = '0;
        cycle("t4_drain");
        chk("t4_drain_valid", rsp_valid, 0);

        // Operand table, including truncation boundaries
        for (int i = 0; i < 8; i++) begin
            v                = '0;
            v[tbl[i].req]    = 1'b1;
            ta[tbl[i].req]   = tbl[i].a;
            tbv[tbl[i].req]  = tbl[i].b;
            rr               = 1'b1;
            cycle("tbl");
            chk("tbl_p_exact", rsp_p, tbl[i].p);
            chk("tbl_id_exact", rsp_id, tbl[i].req);
        end
        v = '0;
        cycle("tbl_end");

        // Asynchronous reset with a held product and pending requests
        v      = 4'b0011;
        ta[0]  = 9'd7;
        tbv[0] = 5'd3;
        ta[1]  = 9'd9;
        tbv[1] = 5'd2;
        rr     = 1'b0;
        cycle("t6_pre");
        chk("t6_pre_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", rsp_valid, 0);
        chk("t6_rst_ready", ready, 0);
        chk("t6_rst_cnt", op_count, 0);
        model_reset();
        v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v  = 4'b0011;
        rr = 1'b1;
        cycle("t6_post");
        chk("t6_post_ready", last_ready, 4'b0001);
        chk("t6_post_id", rsp_id, 0);

        // Random traffic, including requests dropped before acceptance
        for (int n = 0; n < 500; n++) begin
            v = N'($urandom);
            for (int i = 0; i < N; i++) begin
                ta[i]  = AW'($urandom);
                tbv[i] = BW'($urandom);
            end
            rr = ($urandom % 4) != 0;
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
